uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter with a one-word holding register in front of the shifter.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic                 ack,
  input  logic [DIV_WIDTH-1:0] div,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  localparam logic [DIV_WIDTH:0] BAUD_ONE = {{DIV_WIDTH{1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;
  logic [7:0]           hold_reg;
  logic                 hold_full;
  logic [7:0]           shift_reg;
  logic [DIV_WIDTH:0]   baud_cnt;
  logic [2:0]           bit_cnt;
  logic                 tx_next;
  logic                 bit_end;
  logic                 last_bit;
  logic                 load;
  logic                 after_data_tx;

  // The baud counter underflows into its MSB on the last cycle of each bit
  assign bit_end  = baud_cnt[DIV_WIDTH];
  assign last_bit = (bit_cnt == 3'd7);
  assign load     = hold_full && ((state == IDLE) || (state == STOP && bit_end));

  assign ack  = rst_n & valid & ~hold_full;
  assign busy = hold_full | (state != IDLE);

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
    end else if (load) begin
      parity_bit <= (^hold_reg) ^ parity_odd;
    end
  end

  assign after_data_tx = parity_bit;
`else
  assign after_data_tx = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && last_bit) state_next = AFTER_DATA;
`ifdef UART_TX_PARITY_EN
      PARITY:  if (bit_end) state_next = STOP;
`endif
      STOP:    if (bit_end) state_next = hold_full ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered, so this computes the level driven from the next edge on
  always_comb begin
    tx_next = tx;
    if (load) begin
      tx_next = 1'b0;
    end else if (bit_end) begin
      case (state)
        START:   tx_next = shift_reg[0];
        DATA:    tx_next = last_bit ? after_data_tx : shift_reg[1];
        default: tx_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
    end else begin
      tx <= tx_next;

      if (ack) begin
        hold_reg  <= data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shift_reg <= hold_reg;
      end else if (state == DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end

      // div is only sampled here, at the start of each bit
      if (load || (state != IDLE && bit_end)) begin
        baud_cnt <= {1'b0, div};
      end else if (state != IDLE) begin
        baud_cnt <= baud_cnt - BAUD_ONE;
      end

      if (state == DATA && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a frame-level reference model.
// Define UART_TX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic [7:0] div;
  logic       parity_odd;
  logic       tx;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int low_cnt  = 0;

  // Reference model: a frame is a list of line levels, each lasting div+2 cycles
  logic [7:0] m_hold;
  bit         m_hold_full = 1'b0;
  bit         m_active    = 1'b0;
  bit         m_level     = 1'b1;
  int         m_left      = 0;
  bit         m_bits[$];
  bit         m_acc       = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.DIV_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .valid(valid),
    .ack(ack),
    .div(div),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx),
    .busy(busy)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_lows(input logic [7:0] w, input bit odd);
    int n;
    n = 1 + 8 - $countones(w);
    if (PAR_EN && (((^w) ^ odd) == 1'b0)) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_active    = 1'b0;
    m_level     = 1'b1;
    m_left      = 0;
    m_acc       = 1'b0;
    m_bits.delete();
  endtask

  // Advance the model across one clock edge using the inputs held before it
  task automatic model_step();
    bit hf_pre;
    m_acc = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hf_pre = m_hold_full;
    if (m_active) begin
      if (m_left > 1) begin
        m_left--;
      end else if (m_bits.size() > 0) begin
        m_level = m_bits.pop_front();
        m_left  = int'(div) + 2;
      end else begin
        m_active = 1'b0;
        m_level  = 1'b1;
      end
    end
    if (!m_active && hf_pre) begin
      m_active = 1'b1;
      m_level  = 1'b0;
      m_left   = int'(div) + 2;
      m_bits.delete();
      for (int i = 0; i < 8; i++) m_bits.push_back(m_hold[i]);
      if (PAR_EN) m_bits.push_back((^m_hold) ^ parity_odd);
      m_bits.push_back(1'b1);
      m_hold_full = 1'b0;
    end
    if (valid && !hf_pre) begin
      m_hold      = data;
      m_hold_full = 1'b1;
      m_acc       = 1'b1;
    end
  endtask

  task automatic cycle();
    #1;
    chk("ack", ack, rst_n & valid & ~m_hold_full);
    @(posedge clk);
    model_step();
    #1;
    chk("tx", tx, m_level);
    chk("busy", busy, m_hold_full | m_active);
    if (busy === 1'b1) busy_cnt++;
    if (tx === 1'b0) low_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic applyStimulus(input logic [7:0] w, input bit keep);
    int n;
    n     = 0;
    valid = 1'b1;
    data  = w;
    m_acc = 1'b0;
    while (!m_acc && n < 6000) begin
      cycle();
      n++;
    end
    if (!m_acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout: observed=no_accept expected=accept word=%h", w);
    end
    if (!keep) valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_active || m_hold_full) && n < 6000) begin
      cycle();
      n++;
    end
    if (m_active || m_hold_full) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: observed=active expected=idle");
    end
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    low_cnt  = 0;
  endtask

  initial begin
    // Reset with no clock edge, then held across several edges with valid high
    rst_n = 1'b1; valid = 1'b0; data = 8'h00; div = 8'd2; parity_odd = 1'b0;
    #2 rst_n = 1'b0; valid = 1'b1; data = 8'hAA;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 1'b0);
    model_reset();
    run(3);
    rst_n = 1'b1; valid = 1'b0;
    run(2);

    // Single word, div=2
    div = 8'd2;
    clear_counts();
    applyStimulus(8'h55, 1'b0);
    wait_idle();
    run(3);
    chk_int("single_busy_cycles", busy_cnt, 1 + NBITS * 4);
    chk_int("single_low_cycles", low_cnt, frame_lows(8'h55, 1'b0) * 4);

    // Back-to-back with valid held high, div=0
    div = 8'd0;
    clear_counts();
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'h0F, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    wait_idle();
    run(3);
    chk_int("b2b_busy_cycles", busy_cnt, 1 + 3 * NBITS * 2);
    chk_int("b2b_low_cycles", low_cnt,
            (frame_lows(8'hA3, 1'b0) + frame_lows(8'h0F, 1'b0) + frame_lows(8'hFF, 1'b0)) * 2);

    // Largest divisor
    div = 8'd255;
    clear_counts();
    applyStimulus(8'h00, 1'b0);
    wait_idle();
    run(3);
    chk_int("div255_busy_cycles", busy_cnt, 1 + NBITS * 257);
    chk_int("div255_low_cycles", low_cnt, frame_lows(8'h00, 1'b0) * 257);

    // Divisor changed mid-bit affects only following bits
    div = 8'd3;
    applyStimulus(8'h96, 1'b0);
    run(6);
    div = 8'd1;
    run(10);
    div = 8'd4;
    wait_idle();
    run(3);

    // Valid offered while hold is full, then withdrawn before ack
    div = 8'd1;
    clear_counts();
    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'hC3, 1'b0);
    valid = 1'b1; data = 8'h99;
    run(3);
    valid = 1'b0;
    wait_idle();
    run(40);
    chk_int("withdraw_busy_cycles", busy_cnt, 1 + 2 * NBITS * 3);

    // Asynchronous reset mid-frame with a word waiting in hold
    div = 8'd2;
    applyStimulus(8'hE7, 1'b0);
    applyStimulus(8'h11, 1'b0);
    run(15);
    rst_n = 1'b0; valid = 1'b1; data = 8'h42;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ack", ack, 1'b0);
    model_reset();
    run(3);
    rst_n = 1'b1; valid = 1'b0;
    run(30);
    clear_counts();
    applyStimulus(8'h5A, 1'b0);
    wait_idle();
    run(3);
    chk_int("postrst_busy_cycles", busy_cnt, 1 + NBITS * 4);

`ifdef UART_TX_PARITY_EN
    div = 8'd2;
    parity_odd = 1'b0;
    clear_counts();
    applyStimulus(8'h55, 1'b0);
    wait_idle();
    chk_int("par_even55_busy", busy_cnt, 45);
    chk_int("par_even55_low", low_cnt, 24);
    parity_odd = 1'b1;
    clear_counts();
    applyStimulus(8'h55, 1'b0);
    wait_idle();
    chk_int("par_odd55_low", low_cnt, 20);
    parity_odd = 1'b0;
    clear_counts();
    applyStimulus(8'h01, 1'b0);
    wait_idle();
    chk_int("par_even01_low", low_cnt, 32);
`endif

    // Randomized traffic with withdrawals and divisor changes
    for (int i = 0; i < 3000; i++) begin
      if (valid && !m_acc) begin
        if ($urandom_range(0, 15) == 0) valid = 1'b0;
      end else begin
        valid = ($urandom_range(0, 2) == 0);
        data  = 8'($urandom);
      end
      if ($urandom_range(0, 39) == 0) div = 8'($urandom_range(0, 5));
      parity_odd = 1'($urandom_range(0, 1));
      cycle();
    end
    valid = 1'b0;
    wait_idle();
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
